// File: rtl/psram_line_arbiter.sv
// Purpose: round-robin arbiter sharing one PSRAM line controller between CPU cache (port 0) and video/DMA fetcher (port 1).
// Latency: a request sampled in IDLE raises mem_rd/mem_wr the next cycle (ISSUE); rq_done pulses the cycle after busy falls.
// Backpressure: requests are level-held; no grant while the controller is busy, one line transaction outstanding at a time.
//
// Ports:
//   mem_clk, reset                      clock, synchronous active-high reset
//   rq_rd/rq_wr[1:0]                    per-port fill / write-back requests (level, held until rq_done)
//   rq_raddr0/1, rq_waddr0/1            per-port line addresses, stable while the request is held
//   rq_wdata0/1                         per-port write-back line data
//   rq_rdata, rq_cen, rq_cwe, rq_caddr  controller cache-side strobes and fill data routed to the granted port
//   rq_gnt, rq_done                     one-hot grant (ISSUE..DONE) and one-cycle completion pulse
//   mem_rd, mem_wr, raddr, waddr        controller command pulses and addresses (addresses registered at grant)
//   cache_rdata                         write-back data of the granted port, to the controller
//   cache_wdata, cache_en, cache_we,
//   cache_addr, rd_busy, wr_busy        controller-side inputs
//   wd_err                              sticky watchdog error
//
// Optional feature: define ARB_WATCHDOG_EN to abort a transaction whose busy never rises within
// WD_CYCLES cycles of ISSUE. Without it WAIT_BUSY waits indefinitely and wd_err is constant 0.

module psram_line_arbiter #(
    parameter int AW        = 18,
    parameter int DW        = 128,
    parameter int WD_CYCLES = 64
) (
    input  logic          mem_clk,
    input  logic          reset,
    input  logic [1:0]    rq_rd,
    input  logic [1:0]    rq_wr,
    input  logic [AW-1:0] rq_waddr0,
    input  logic [AW-1:0] rq_waddr1,
    input  logic [AW-1:0] rq_raddr0,
    input  logic [AW-1:0] rq_raddr1,
    input  logic [DW-1:0] rq_wdata0,
    input  logic [DW-1:0] rq_wdata1,
    output logic [DW-1:0] rq_rdata,
    output logic [1:0]    rq_cen,
    output logic          rq_cwe,
    output logic [1:0]    rq_caddr,
    output logic [1:0]    rq_done,
    output logic [1:0]    rq_gnt,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic [DW-1:0] cache_rdata,
    input  logic [DW-1:0] cache_wdata,
    input  logic          cache_en,
    input  logic          cache_we,
    input  logic [1:0]    cache_addr,
    input  logic          rd_busy,
    input  logic          wr_busy,
    output logic          wd_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t     state;
    logic       last;      // index of the most recently granted port
    logic       busy;
    logic [1:0] req;
    logic       pick;      // winning port index when a grant is made this cycle

    assign busy = rd_busy | wr_busy;
    assign req  = rq_rd | rq_wr;

    // Lone requester wins; on a tie the port that was not served last wins.
    assign pick = (req == 2'b11) ? ~last : req[1];

`ifdef ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);
    logic [WDW-1:0] wd_cnt;   // cycles since ISSUE (0 in the ISSUE cycle)
    logic           wd_err_q;
`endif

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            state  <= S_IDLE;
            last   <= 1'b1;
            rq_gnt <= 2'b00;
            rq_done <= 2'b00;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            waddr  <= '0;
            raddr  <= '0;
`ifdef ARB_WATCHDOG_EN
            wd_cnt   <= '0;
            wd_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if ((req != 2'b00) && !busy) begin
                        rq_gnt <= pick ? 2'b10 : 2'b01;
                        last   <= pick;
                        raddr  <= pick ? rq_raddr1 : rq_raddr0;
                        waddr  <= pick ? rq_waddr1 : rq_waddr0;
                        // Command pulses are the latched request flags, visible during ISSUE.
                        mem_rd <= rq_rd[pick];
                        mem_wr <= rq_wr[pick];
                        state  <= S_ISSUE;
`ifdef ARB_WATCHDOG_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    state  <= S_WAIT_BUSY;
`ifdef ARB_WATCHDOG_EN
                    wd_cnt <= wd_cnt + 1'b1;
`endif
                end
                S_WAIT_BUSY: begin
                    if (busy) begin
                        state <= S_WAIT_DONE;
                    end
`ifdef ARB_WATCHDOG_EN
                    // Abort so a dead controller cannot starve both requesters forever;
                    // the completion pulse lets the requester drop its level request.
                    else if (wd_cnt == WDW'(WD_CYCLES - 1)) begin
                        wd_err_q <= 1'b1;
                        rq_done  <= rq_gnt;
                        state    <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                S_WAIT_DONE: begin
                    if (!busy) begin
                        rq_done <= rq_gnt;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    rq_done <= 2'b00;
                    rq_gnt  <= 2'b00;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Controller strobes reach a requester only while its transaction is in flight;
    // anything the controller does around ISSUE/DONE is not ours to forward.
    assign rq_cen      = ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) ?
                         ({2{cache_en}} & rq_gnt) : 2'b00;
    assign rq_cwe      = cache_we;
    assign rq_caddr    = cache_addr;
    assign rq_rdata    = cache_wdata;
    assign cache_rdata = rq_gnt[1] ? rq_wdata1 : rq_wdata0;

`ifdef ARB_WATCHDOG_EN
    assign wd_err = wd_err_q;
`else
    // Folds to constant 0 for any legal WD_CYCLES; keeps the parameter referenced in this build.
    assign wd_err = (WD_CYCLES < 0);
`endif

endmodule

// File: tb/tb_psram_line_arbiter.sv
// Bench for psram_line_arbiter: behavioural transaction model checked every cycle plus directed scenarios.
// Stimulus processes are phase-separated after each posedge: reset/config +1, controller +2, requesters +3.
// Outputs are sampled on the falling edge.
module tb_psram_line_arbiter;
    localparam int AW = 18;
    localparam int DW = 128;
    localparam int WD = 64;

    logic          mem_clk, reset;
    logic [1:0]    rq_rd, rq_wr;
    logic [AW-1:0] rq_waddr0, rq_waddr1, rq_raddr0, rq_raddr1;
    logic [DW-1:0] rq_wdata0, rq_wdata1, rq_rdata;
    logic [1:0]    rq_cen, rq_caddr, rq_done, rq_gnt;
    logic          rq_cwe, mem_rd, mem_wr;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] cache_rdata, cache_wdata;
    logic          cache_en, cache_we;
    logic [1:0]    cache_addr;
    logic          rd_busy, wr_busy, wd_err;

    psram_line_arbiter #(.AW(AW), .DW(DW), .WD_CYCLES(WD)) dut (
        .mem_clk(mem_clk), .reset(reset),
        .rq_rd(rq_rd), .rq_wr(rq_wr),
        .rq_waddr0(rq_waddr0), .rq_waddr1(rq_waddr1),
        .rq_raddr0(rq_raddr0), .rq_raddr1(rq_raddr1),
        .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
        .rq_rdata(rq_rdata), .rq_cen(rq_cen), .rq_cwe(rq_cwe), .rq_caddr(rq_caddr),
        .rq_done(rq_done), .rq_gnt(rq_gnt),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .waddr(waddr), .raddr(raddr),
        .cache_rdata(cache_rdata), .cache_wdata(cache_wdata),
        .cache_en(cache_en), .cache_we(cache_we), .cache_addr(cache_addr),
        .rd_busy(rd_busy), .wr_busy(wr_busy), .wd_err(wd_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        mem_clk = 1'b0;
        forever #5 mem_clk = ~mem_clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge mem_clk);
        cyc++;
    end

    // Test knobs (written by the main sequence only)
    bit pre_busy = 0;   // controller reports busy with no transaction
    bit stray    = 0;   // controller raises cache_en outside any transaction
    bit stuck    = 0;   // controller ignores commands (busy never rises)
    bit cfg_rd[2];
    bit cfg_wr[2];
    int rem[2];         // transactions each requester still has to make
    int raise_cyc[2];

    // Requesters: raise a request when idle and transactions remain, drop it on rq_done or reset.
    initial begin
        rq_rd = 2'b00;
        rq_wr = 2'b00;
        forever begin
            @(posedge mem_clk);
            #3;
            for (int n = 0; n < 2; n++) begin
                if (reset || rq_done[n]) begin
                    rq_rd[n] = 1'b0;
                    rq_wr[n] = 1'b0;
                end else if (!(rq_rd[n] | rq_wr[n]) && rem[n] > 0) begin
                    rq_rd[n] = cfg_rd[n];
                    rq_wr[n] = cfg_wr[n];
                    rem[n]--;
                    raise_cyc[n] = cyc;
                end
            end
        end
    end

    // Controller stand-in: one idle cycle after a command, then 8 busy cycles.
    // Write-back strobes (we=1) on busy cycles 0-3, fill strobes on busy cycles 4-7.
    initial begin
        bit t_rd, t_wr;
        logic [31:0] w;
        rd_busy = 0; wr_busy = 0; cache_en = 0; cache_we = 0; cache_addr = 0; cache_wdata = '0;
        forever begin
            @(posedge mem_clk);
            #2;
            rd_busy  = pre_busy;
            cache_en = stray;
            cache_we = 1'b0;
            if (!reset && !stuck && (mem_rd || mem_wr)) begin
                t_rd = mem_rd;
                t_wr = mem_wr;
                @(posedge mem_clk);
                #2;
                for (int i = 0; i < 8; i++) begin
                    if (reset) break;
                    rd_busy     = t_rd;
                    wr_busy     = t_wr;
                    cache_en    = (t_wr && i < 4) || (t_rd && i >= 4);
                    cache_we    = t_wr && i < 4;
                    cache_addr  = 2'(i);
                    w           = 32'hF00D_0000 + 32'(i);
                    cache_wdata = {w, w, w, w};
                    @(posedge mem_clk);
                    #2;
                end
                rd_busy  = pre_busy;
                wr_busy  = 1'b0;
                cache_en = 1'b0;
                cache_we = 1'b0;
            end
        end
    end

    // Behavioural model: a transaction is granted, issued for one cycle, waits for busy
    // to rise and fall, completes with a one-cycle done. Expected outputs derive from it.
    bit            mdl_ok = 0;
    logic [1:0]    m_gnt;
    bit            m_issue, m_done, m_seen, m_rd, m_wr, m_last, m_wd;
    logic [AW-1:0] m_raddr, m_waddr;
    int            m_age;

    // Event log from the DUT, used by the directed checks
    int            done_total = 0, done_cyc = 0, rd_cyc = 0, busy_fall_cyc = 0, cen0_n = 0, both_n = 0;
    int            gq[$];
    logic [AW-1:0] cap_waddr, cap_raddr;
    logic [DW-1:0] cap_crd;
    logic [1:0]    prev_gnt = 2'b00;
    bit            prev_busy = 0;

    initial forever begin
        logic [1:0] e_cen, pend;
        bit         bz, w;
        @(negedge mem_clk);
        bz = rd_busy | wr_busy;
        if (mdl_ok) begin
            e_cen = (m_gnt != 2'b00 && !m_issue && !m_done && cache_en) ? m_gnt : 2'b00;
            chk("gnt", rq_gnt, m_gnt);
            chk("mem_rd", mem_rd, m_issue & m_rd);
            chk("mem_wr", mem_wr, m_issue & m_wr);
            chk("done", rq_done, m_done ? m_gnt : 2'b00);
            chk("raddr", raddr, m_raddr);
            chk("waddr", waddr, m_waddr);
            chk("cen", rq_cen, e_cen);
            chk("cache_rdata", cache_rdata, m_gnt[1] ? rq_wdata1 : rq_wdata0);
            chk("rq_rdata", rq_rdata, cache_wdata);
            chk("cwe_caddr", {rq_caddr, rq_cwe}, {cache_addr, cache_we});
            chk("wd_err", wd_err, m_wd);
            if (mem_rd || mem_wr) chk("cmd_while_busy", bz, 1'b0);
        end
        if (mem_rd === 1'b1) rd_cyc = cyc;
        if (mem_rd === 1'b1 && mem_wr === 1'b1) begin
            both_n++;
            cap_waddr = waddr;
            cap_raddr = raddr;
            cap_crd   = cache_rdata;
        end
        if (rq_done !== 2'b00 && !$isunknown(rq_done)) begin
            done_total++;
            done_cyc = cyc;
        end
        if (prev_gnt == 2'b00 && (rq_gnt == 2'b01 || rq_gnt == 2'b10)) gq.push_back(rq_gnt[1] ? 1 : 0);
        if (prev_busy && !bz) busy_fall_cyc = cyc;
        if (rq_cen[0] === 1'b1 && rq_cwe === 1'b0) cen0_n++;
        prev_gnt  = $isunknown(rq_gnt) ? 2'b00 : rq_gnt;
        prev_busy = bz;

        // Advance the model to what the next cycle must show.
        pend = rq_rd | rq_wr;
        if (reset) begin
            m_gnt = 0; m_issue = 0; m_done = 0; m_seen = 0; m_rd = 0; m_wr = 0;
            m_raddr = '0; m_waddr = '0; m_last = 1; m_wd = 0; m_age = 0;
            mdl_ok = 1;
        end else if (m_done) begin
            m_gnt  = 2'b00;
            m_done = 0;
        end else if (m_gnt == 2'b00) begin
            if (pend != 2'b00 && !bz) begin
                w       = (pend == 2'b11) ? !m_last : pend[1];
                m_gnt   = w ? 2'b10 : 2'b01;
                m_last  = w;
                m_rd    = rq_rd[w];
                m_wr    = rq_wr[w];
                m_raddr = w ? rq_raddr1 : rq_raddr0;
                m_waddr = w ? rq_waddr1 : rq_waddr0;
                m_issue = 1;
                m_age   = 0;
            end
        end else if (m_issue) begin
            m_issue = 0;
            m_seen  = 0;
            m_age   = 1;
        end else if (!m_seen) begin
            if (bz) m_seen = 1;
`ifdef ARB_WATCHDOG_EN
            else if (m_age == WD - 1) begin
                m_done = 1;
                m_wd   = 1;
            end else m_age++;
`endif
        end else if (!bz) begin
            m_done = 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge mem_clk);
        #4;
    endtask

    task automatic wait_done(input int target, input int budget, input string nm);
        int k = 0;
        while (done_total < target && k < budget) begin
            step(1);
            k++;
        end
        chk(nm, done_total >= target, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge mem_clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge mem_clk);
        #1 reset = 1'b0;
        step(1);
    endtask

    initial begin
        int d0, g0, c0, b0, found;
        logic [DW-1:0] wd1;
        reset = 1'b1;
        rq_raddr0 = '0; rq_raddr1 = '0; rq_waddr0 = '0; rq_waddr1 = '0;
        rq_wdata0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        rq_wdata1 = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
        wd1 = rq_wdata1;
        cfg_rd[0] = 0; cfg_rd[1] = 0; cfg_wr[0] = 0; cfg_wr[1] = 0; rem[0] = 0; rem[1] = 0;
        repeat (3) @(posedge mem_clk);
        #4;
        chk("rst_gnt", rq_gnt, 2'b00);
        chk("rst_cmd", {mem_rd, mem_wr, rq_done}, 4'b0);
        chk("rst_addr", {raddr, waddr}, '0);
        chk("rst_wd", wd_err, 1'b0);
        @(posedge mem_clk);
        #1 reset = 1'b0;
        step(1);

        // Simultaneous requests straight after reset: port 0 first, then strict alternation.
        g0 = gq.size();
        d0 = done_total;
        rq_raddr0 = 18'h00AA0; rq_raddr1 = 18'h00BB0;
        cfg_rd[0] = 1; cfg_rd[1] = 1;
        rem[0] = 4; rem[1] = 4;
        wait_done(d0 + 8, 400, "t2_timeout");
        chk("t2_grants", gq.size() - g0, 8);
        for (int i = 0; i < 8 && g0 + i < gq.size(); i++) chk("t2_order", gq[g0 + i], i % 2);

        // Single fill from port 0, with stray cache_en that must never be forwarded.
        do_reset();
        stray = 1;
        step(3);
        chk("t1_stray_idle", rq_cen, 2'b00);
        rq_raddr0 = 18'h00123; rq_waddr0 = 18'h0AAAA;
        cfg_rd[0] = 1; cfg_wr[0] = 0;
        c0 = cen0_n;
        d0 = done_total;
        rem[0] = 1;
        wait_done(d0 + 1, 60, "t1_timeout");
        // request cycle, then ISSUE: mem_rd is seen one edge after the request is raised
        chk("t1_rd_lat", rd_cyc - raise_cyc[0], 1);
        chk("t1_raddr", raddr, 18'h00123);
        chk("t1_fills", cen0_n - c0, 4);
        chk("t1_done_after_busy", done_cyc - busy_fall_cyc, 1);
        chk("t1_done_lat", done_cyc - raise_cyc[0], 11);
        stray = 0;
        step(2);

        // Port 1 write-back + fill in one transaction.
        rq_waddr1 = 18'h3FFFF; rq_raddr1 = 18'h00000;
        cfg_rd[1] = 1; cfg_wr[1] = 1;
        b0 = both_n;
        d0 = done_total;
        rem[1] = 1;
        wait_done(d0 + 1, 60, "t3_timeout");
        chk("t3_both_once", both_n - b0, 1);
        chk("t3_waddr", cap_waddr, 18'h3FFFF);
        chk("t3_raddr", cap_raddr, 18'h00000);
        chk("t3_wb_data", cap_crd, wd1);
        step(2);

        // Request while the controller is still busy: no grant until busy drops.
        pre_busy = 1;
        step(2);
        g0 = gq.size();
        d0 = done_total;
        cfg_rd[0] = 1; cfg_wr[0] = 0;
        rem[0] = 1;
        step(6);
        chk("t4_no_grant", gq.size() - g0, 0);
        chk("t4_gnt_low", rq_gnt, 2'b00);
        pre_busy = 0;
        wait_done(d0 + 1, 60, "t4_timeout");
        chk("t4_granted", gq.size() - g0, 1);
        step(2);

        // Reset in WAIT_DONE: transaction vanishes without a done pulse.
        rem[0] = 1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step(1);
            if (rq_cen != 2'b00) found = 1;
        end
        chk("t5_reached_wait_done", found, 1);
        d0 = done_total;
        @(posedge mem_clk);
        #1 reset = 1'b1;
        step(1);
        chk("t5_gnt", rq_gnt, 2'b00);
        chk("t5_cmd", {mem_rd, mem_wr, rq_done}, 4'b0);
        @(posedge mem_clk);
        #1 reset = 1'b0;
        step(4);
        chk("t5_no_done", done_total - d0, 0);

`ifdef ARB_WATCHDOG_EN
        // Controller never goes busy: watchdog completes the transaction WD cycles after ISSUE.
        stuck = 1;
        d0 = done_total;
        rem[0] = 1;
        wait_done(d0 + 1, 120, "t6_timeout");
        chk("t6_wd_lat", done_cyc - rd_cyc, WD);
        chk("t6_wd_err", wd_err, 1'b1);
        stuck = 0;
        step(2);
        chk("t6_idle_after", rq_gnt, 2'b00);
        chk("t6_sticky", wd_err, 1'b1);
`endif

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish at time %0t", $time);
        $fatal(1);
    end
endmodule
